// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program run controller: state encoding,
// program count and the per-program end address table.
package prog_seq_pkg;

  localparam int NPROG = 5;
  localparam int IDXW  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    RESET  = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    REPORT = 3'd5,
    FIN    = 3'd6
  } state_t;

  // PC value at which each test program is considered finished.
  function automatic logic [31:0] end_addr(input logic [IDXW-1:0] idx);
    case (idx)
      3'd0:    end_addr = 32'd92;
      3'd1:    end_addr = 32'd56;
      3'd2:    end_addr = 32'd100;
      3'd3:    end_addr = 32'd148;
      3'd4:    end_addr = 32'd180;
      default: end_addr = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_prog_pick.sv
// Combinational search for the lowest enabled program index at or above i_from.
module prog_pick
  import prog_seq_pkg::*;
#(
  parameter int MASK_W = NPROG
) (
  input  logic [MASK_W-1:0] i_mask,
  input  logic [IDXW-1:0]   i_from,
  output logic [IDXW-1:0]   o_idx,
  output logic              o_none
);

  // Scanning downward leaves the lowest qualifying index as the final winner.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_from))) begin
        o_idx  = IDXW'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: steps through enabled programs, holds the core in reset between
// runs, watches the PC for the end address or a timeout and reports one result each.
module prog_sequencer #(
  parameter int NPROG      = prog_seq_pkg::NPROG,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NPROG-1:0] prog_mask,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_gpio,
  output logic             core_reset,
  output logic [2:0]       core_cod,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [2:0]       result_idx,
  output logic [31:0]      result_gpio,
  output logic [15:0]      result_cycles,
  output logic             result_timeout,
  output logic [2:0]       o_dbg_state
);
  import prog_seq_pkg::*;

  state_t             r_state;
  state_t             w_next;
  logic [NPROG-1:0]   r_mask;
  logic [IDXW-1:0]    r_idx;
  logic [15:0]        r_rcnt;
  logic [15:0]        r_cyc;
  logic               r_core_reset;
  logic [2:0]         r_core_cod;
  logic               r_busy;
  logic               r_done;
  logic               r_rv;
  logic [2:0]         r_res_idx;
  logic [31:0]        r_res_gpio;
  logic [15:0]        r_res_cycles;
  logic               r_res_to;
  logic [IDXW-1:0]    w_from;
  logic [IDXW-1:0]    w_pick_idx;
  logic               w_pick_none;

  // SELECT searches from the current index; REPORT asks whether anything lies above it.
  assign w_from = (r_state == REPORT) ? r_idx + 3'd1 : r_idx;

  prog_pick #(.MASK_W(NPROG)) u_pick (
    .i_mask (r_mask),
    .i_from (w_from),
    .o_idx  (w_pick_idx),
    .o_none (w_pick_none)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (prog_mask == '0) ? FIN : SELECT;
      SELECT:  w_next = w_pick_none ? FIN : RESET;
      RESET:   if (r_rcnt <= 16'd1) w_next = RUN;
      RUN: begin
        if (core_pc == end_addr(r_idx))  w_next = DRAIN;
        else if (r_cyc == 16'(TIMEOUT))  w_next = REPORT;
      end
      DRAIN:   w_next = REPORT;
      REPORT:  w_next = w_pick_none ? FIN : SELECT;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  // Output flops are loaded from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_rcnt       <= '0;
      r_cyc        <= '0;
      r_core_reset <= 1'b1;
      r_core_cod   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rv         <= 1'b0;
      r_res_idx    <= '0;
      r_res_gpio   <= '0;
      r_res_cycles <= '0;
      r_res_to     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_core_reset <= !((w_next == RUN) || (w_next == DRAIN));
      r_busy       <= (w_next != IDLE);
      r_done       <= (w_next == FIN);
      r_rv         <= (w_next == REPORT);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mask <= prog_mask;
            r_idx  <= '0;
          end
        end
        SELECT: begin
          r_idx      <= w_pick_idx;
          r_core_cod <= w_pick_idx;
          r_rcnt     <= 16'(RST_CYCLES);
        end
        RESET: begin
          r_rcnt <= r_rcnt - 16'd1;
          r_cyc  <= 16'd1;
        end
        RUN:     if (w_next == RUN) r_cyc <= r_cyc + 16'd1;
        REPORT:  r_idx <= r_idx + 3'd1;
        default: ;
      endcase
      if (w_next == REPORT) begin
        r_res_idx    <= r_idx;
        r_res_gpio   <= core_gpio;
        r_res_cycles <= r_cyc;
        r_res_to     <= (r_state == RUN);
      end
    end
  end

  assign core_reset     = r_core_reset;
  assign core_cod       = r_core_cod;
  assign busy           = r_busy;
  assign done           = r_done;
  assign result_valid   = r_rv;
  assign result_idx     = r_res_idx;
  assign result_gpio    = r_res_gpio;
  assign result_cycles  = r_res_cycles;
  assign result_timeout = r_res_to;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a behavioural core model answers the sequencer, results
// are predicted per program at start and matched by a monitor as they are reported.
module tb_prog_sequencer;

  localparam int NPROG      = 5;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 24;
  localparam int W          = 52;  // {idx[3], timeout[1], cycles[16], gpio[32]}

  logic        CLK = 1'b0;
  logic        Reset, start, abort;
  logic [4:0]  prog_mask;
  logic [31:0] core_pc, core_gpio;
  logic        core_reset, busy, done, result_valid, result_timeout;
  logic [2:0]  core_cod, result_idx, dbg_state;
  logic [31:0] result_gpio;
  logic [15:0] result_cycles;

  prog_sequencer #(.NPROG(NPROG), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .abort(abort), .prog_mask(prog_mask),
    .core_pc(core_pc), .core_gpio(core_gpio), .core_reset(core_reset), .core_cod(core_cod),
    .busy(busy), .done(done), .result_valid(result_valid), .result_idx(result_idx),
    .result_gpio(result_gpio), .result_cycles(result_cycles),
    .result_timeout(result_timeout), .o_dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int          hit_at [8];   // RUN cycle at which the core reaches its end PC, 0 = never
  logic [31:0] seed   [8];   // settled GPIO value per program
  logic [W-1:0] exp_q[$];
  logic [4:0]  cur_mask;
  int n_checks, n_err, done_seen, exp_done, cyc, sel_cyc, run_cnt, guard;
  logic prev_rv, prev_busy, prev_core_reset;

  function automatic logic [31:0] ref_end(input int idx);
    case (idx)
      0: return 32'd92;
      1: return 32'd56;
      2: return 32'd100;
      3: return 32'd148;
      4: return 32'd180;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: counts cycles out of reset, hits its end PC at hit_at, GPIO settles after.
  always @(negedge CLK) begin
    int h;
    if (core_reset) run_cnt = 0;
    else            run_cnt++;
    h = hit_at[core_cod];
    core_pc   = (h != 0 && run_cnt == h) ? ref_end(int'(core_cod)) : 32'h1000 + 32'(run_cnt);
    core_gpio = (h != 0 && run_cnt > h) ? seed[core_cod] : seed[core_cod] ^ 32'hFFFF_0000;
  end

  // Monitor
  always @(negedge CLK) begin
    logic [W-1:0] e;
    cyc++;
    if (!Reset) begin
      if (result_valid) begin
        check("rv_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_idx",     64'(result_idx),     64'(e[51:49]));
          check("res_timeout", 64'(result_timeout), 64'(e[48]));
          check("res_cycles",  64'(result_cycles),  64'(e[47:32]));
          check("res_gpio",    64'(result_gpio),    64'(e[31:0]));
        end
        sel_cyc = cyc + 1;
      end
      if (done) begin
        check("done_pending", 64'(exp_q.size()), 64'd0);
        check("done_after_report", 64'(prev_rv), 64'(cur_mask != 5'd0));
        done_seen++;
      end
      if (busy && !prev_busy) sel_cyc = cyc;
      if (prev_core_reset && !core_reset) begin
        check("reset_len", 64'(cyc - sel_cyc), 64'(1 + RST_CYCLES));
        check("run_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("run_cod", 64'(core_cod), 64'(exp_q[0][51:49]));
      end
    end
    prev_rv         = result_valid;
    prev_busy       = busy;
    prev_core_reset = core_reset;
  end

  task automatic push_expected(input logic [4:0] m);
    cur_mask = m;
    for (int i = 0; i < NPROG; i++) begin
      if (m[i]) begin
        if (hit_at[i] >= 1 && hit_at[i] <= TIMEOUT)
          exp_q.push_back({3'(i), 1'b0, 16'(hit_at[i]), seed[i]});
        else
          exp_q.push_back({3'(i), 1'b1, 16'(TIMEOUT), seed[i] ^ 32'hFFFF_0000});
      end
    end
  endtask

  task automatic run_seq(input logic [4:0] m, input bit noisy);
    int g;
    push_expected(m);
    exp_done++;
    @(negedge CLK);
    start = 1'b1;
    prog_mask = m;
    @(negedge CLK);
    start = 1'b0;
    prog_mask = 5'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    g = 0;
    while (!done && g < 6 * (TIMEOUT + 8) + 20) begin
      @(negedge CLK);
      g++;
      if (noisy && !done) begin
        start     = busy && ($urandom_range(0, 5) == 0);
        prog_mask = 5'($urandom);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    if (!done) exp_q.delete();
    @(negedge CLK);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_core_cod"},   64'(core_cod),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_rv"},         64'(result_valid), 64'd0);
    check({tag, "_res_idx"},    64'(result_idx),   64'd0);
    check({tag, "_res_gpio"},   64'(result_gpio),  64'd0);
    check({tag, "_res_cycles"}, 64'(result_cycles), 64'd0);
    check({tag, "_res_to"},     64'(result_timeout), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; abort = 1'b0; prog_mask = '0;
    core_pc = '0; core_gpio = '0; cur_mask = '0;
    n_checks = 0; n_err = 0; done_seen = 0; exp_done = 0; cyc = 0; sel_cyc = 0;
    run_cnt = 0; prev_rv = 1'b0; prev_busy = 1'b0; prev_core_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hit_at[i] = 0;
      seed[i]   = '0;
    end
    repeat (3) @(negedge CLK);
    check_reset_vals("por");
    Reset = 1'b0;

    // Single program reaching its end address
    hit_at[0] = 23;
    seed[0]   = 32'h1234;
    run_seq(5'b00001, 1'b0);

    // Two programs in index order
    hit_at[1] = $urandom_range(1, TIMEOUT);
    hit_at[4] = $urandom_range(1, TIMEOUT);
    seed[1]   = $urandom;
    seed[4]   = $urandom;
    run_seq(5'b10010, 1'b0);

    // Timeout, then PC match on the timeout cycle itself
    seed[2]   = $urandom;
    hit_at[2] = 0;
    run_seq(5'b00100, 1'b0);
    hit_at[2] = TIMEOUT;
    run_seq(5'b00100, 1'b0);

    // Empty mask
    run_seq(5'b00000, 1'b0);

    // Abort during RUN of program 3
    hit_at[3] = 0;
    seed[3]   = $urandom;
    push_expected(5'b01000);
    @(negedge CLK);
    start = 1'b1;
    prog_mask = 5'b01000;
    @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (core_reset && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    check("abort_reached_run", 64'(core_reset), 64'd0);
    repeat (3) @(negedge CLK);
    abort = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    abort = 1'b0;
    check("abort_core_reset", 64'(core_reset), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rv", 64'(result_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (TIMEOUT + 5) @(negedge CLK);
    hit_at[3] = $urandom_range(1, TIMEOUT);
    run_seq(5'b01000, 1'b0);

    // Reset while in RESET state, with a start pulse ignored
    hit_at[0] = 10;
    push_expected(5'b00001);
    @(negedge CLK);
    start = 1'b1;
    prog_mask = 5'b00001;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("mid_core_reset", 64'(core_reset), 64'd1);
    check("mid_busy", 64'(busy), 64'd1);
    start = 1'b1;
    Reset = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    Reset = 1'b0;
    start = 1'b0;
    check_reset_vals("midrst");

    // Randomized sequences with start noise while busy
    repeat (20) begin
      for (int i = 0; i < NPROG; i++) begin
        hit_at[i] = $urandom_range(0, TIMEOUT + 4);
        seed[i]   = $urandom;
      end
      run_seq(5'($urandom_range(0, 31)), 1'b1);
    end

    check("done_count", 64'(done_seen), 64'(exp_done));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
